// File: rtl/inst_loader.sv
// Download engine: assembles a framed little-endian byte stream into 32-bit
// instruction words and writes them to sequential addresses from 0.
module inst_loader #(
    parameter int AW      = 12,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dl_start,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          wren,
    output logic [AW-1:0] wraddr,
    output logic [31:0]   wrdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} state_t;

    state_t        state;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift;
    logic [AW:0]   word_idx;
    logic [AW:0]   word_len;
    logic [TW-1:0] idle_cnt;

    logic          accept;
    logic [31:0]   full_word;
    logic [AW:0]   next_idx;
    logic          len_bad;

    assign rx_ready  = (state == LEN) || (state == DATA);
    assign busy      = (state != IDLE);
    assign accept    = rx_valid && rx_ready;
    assign full_word = {rx_data, shift};
    assign next_idx  = word_idx + 1'b1;
    // Length is accepted only in 1..2^AW; the compare is done one bit wider
    assign len_bad   = (full_word == 32'd0) || ({1'b0, full_word} > (33'd1 << AW));

    // The idle counter holds the number of cycles since the last accepted byte
    // (or since dl_start), so err lands exactly TIMEOUT cycles after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
            shift    <= '0;
            word_idx <= '0;
            word_len <= '0;
            idle_cnt <= '0;
            wren     <= 1'b0;
            wraddr   <= '0;
            wrdata   <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wren <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (dl_start) begin
                        state    <= LEN;
                        byte_cnt <= '0;
                        word_idx <= '0;
                        idle_cnt <= TW'(1);
                        cpu_hold <= 1'b1;
                    end else begin
                        cpu_hold <= 1'b0;
                    end
                end
                LEN, DATA: begin
                    if (accept) begin
                        idle_cnt <= TW'(1);
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {rx_data, shift[23:8]};
                        if (byte_cnt == 2'd3) begin
                            if (state == LEN) begin
                                if (len_bad) begin
                                    err   <= 1'b1;
                                    state <= IDLE;
                                end else begin
                                    word_len <= full_word[AW:0];
                                    state    <= DATA;
                                end
                            end else begin
                                wren     <= 1'b1;
                                wraddr   <= word_idx[AW-1:0];
                                wrdata   <= full_word;
                                word_idx <= next_idx;
                                if (next_idx == word_len) begin
                                    state <= DONE;
                                end
                            end
                        end
                    end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: frames are built from word lists and the
// observed writes/pulses are checked against cycle stamps of accepted bytes.
module tb_inst_loader;

    localparam int AW      = 4;
    localparam int TIMEOUT = 50;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          dl_start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          rx_ready;
    logic          wren;
    logic [AW-1:0] wraddr;
    logic [31:0]   wrdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    inst_loader #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .dl_start(dl_start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int            acc_q[$];
    int            wr_cyc_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    int            done_cnt, err_cnt, done_cyc, err_cyc, hold_fall_cyc;
    logic          prev_hold = 1'b0;

    logic [7:0]    tx_q[$];
    logic [31:0]   exp_words[$];
    bit            gapped;

    // Passive monitor: every event is stamped with the cycle it was observed in
    always @(negedge clk) begin
        if (rx_valid && rx_ready) acc_q.push_back(cyc);
        if (wren) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(wraddr);
            wr_data_q.push_back(wrdata);
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err)  begin err_cnt++;  err_cyc  = cyc; end
        if (prev_hold && !cpu_hold) hold_fall_cyc = cyc;
        prev_hold = cpu_hold;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        acc_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1; hold_fall_cyc = -1;
    endtask

    task automatic buildFrame(input logic [31:0] n);
        tx_q.delete();
        for (int k = 0; k < 4; k++) tx_q.push_back(8'(n >> (8 * k)));
        foreach (exp_words[w])
            for (int k = 0; k < 4; k++) tx_q.push_back(8'(exp_words[w] >> (8 * k)));
    endtask

    task automatic randomWords(input int n);
        exp_words.delete();
        for (int w = 0; w < n; w++) exp_words.push_back($urandom);
    endtask

    task automatic startTransfer();
        clearLogs();
        @(posedge clk); #1 dl_start = 1'b1;
        @(posedge clk); #1 dl_start = 1'b0;
        @(negedge clk);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_hold", cpu_hold, 1);
        checkOutput("start_ready", rx_ready, 1);
    endtask

    task automatic applyStimulus(input int stop_after, input int mid_start_idx);
        int i = 0;
        int guard = 0;
        while (i < stop_after && guard < 5000) begin
            @(posedge clk); #1;
            rx_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            rx_data  = tx_q[i];
            dl_start = (i == mid_start_idx);
            @(negedge clk);
            if (rx_valid && rx_ready) i++;
            guard++;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        dl_start = 1'b0;
        checkOutput("bytes_sent", i, stop_after);
    endtask

    task automatic waitEnd();
        int k = 0;
        while (done_cnt + err_cnt == 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        checkOutput("end_seen", (done_cnt + err_cnt) != 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkWrites(input int n_exp);
        checkOutput("wr_count", wr_cyc_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < wr_cyc_q.size(); i++) begin
            checkOutput("wr_addr", wr_addr_q[i], i[AW-1:0]);
            checkOutput("wr_data", wr_data_q[i], exp_words[i]);
            if (acc_q.size() > 4 * i + 7)
                checkOutput("wr_cycle", wr_cyc_q[i], acc_q[4 * i + 7] + 1);
            else
                checkOutput("wr_acc_count", acc_q.size(), 4 * i + 8);
        end
    endtask

    task automatic checkSuccess();
        checkWrites(exp_words.size());
        checkOutput("done_cnt", done_cnt, 1);
        checkOutput("err_cnt", err_cnt, 0);
        checkOutput("done_cycle", done_cyc, acc_q[acc_q.size() - 1] + 2);
        checkOutput("hold_fall", hold_fall_cyc, done_cyc + 1);
    endtask

    task automatic checkLenError();
        checkWrites(0);
        checkOutput("lenerr_err_cnt", err_cnt, 1);
        checkOutput("lenerr_done_cnt", done_cnt, 0);
        checkOutput("lenerr_cycle", err_cyc, acc_q[3] + 1);
        checkOutput("lenerr_hold_fall", hold_fall_cyc, err_cyc + 1);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rx_ready"}, rx_ready, 0);
        checkOutput({tag, "_wren"}, wren, 0);
        checkOutput({tag, "_wraddr"}, wraddr, 0);
        checkOutput({tag, "_wrdata"}, wrdata, 0);
        checkOutput({tag, "_cpu_hold"}, cpu_hold, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
    endtask

    initial begin
        clearLogs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed normal load, then the same frame with random gaps
        for (int pass = 0; pass < 2; pass++) begin
            exp_words.delete();
            exp_words.push_back(32'h0000_0013);
            exp_words.push_back(32'hDEAD_BEEF);
            buildFrame(2);
            gapped = (pass == 1);
            startTransfer();
            applyStimulus(tx_q.size(), -1);
            waitEnd();
            checkSuccess();
            if (pass == 0 && wr_cyc_q.size() >= 2)
                checkOutput("wr_spacing", wr_cyc_q[1] - wr_cyc_q[0], 4);
        end

        // Length errors: zero and one past capacity
        exp_words.delete();
        buildFrame(0);
        gapped = 1'b0;
        startTransfer();
        applyStimulus(4, -1);
        waitEnd();
        checkLenError();

        buildFrame(32'((1 << AW) + 1));
        startTransfer();
        applyStimulus(4, -1);
        waitEnd();
        checkLenError();

        // Full capacity, with gaps
        randomWords(1 << AW);
        buildFrame(32'(1 << AW));
        gapped = 1'b1;
        startTransfer();
        applyStimulus(tx_q.size(), -1);
        waitEnd();
        checkSuccess();

        // Random frames
        for (int r = 0; r < 4; r++) begin
            randomWords($urandom_range(1, 1 << AW));
            buildFrame(32'(exp_words.size()));
            gapped = 1'($urandom_range(0, 1));
            startTransfer();
            applyStimulus(tx_q.size(), -1);
            waitEnd();
            checkSuccess();
        end

        // Stall after 1.5 words of a 3-word frame
        randomWords(3);
        buildFrame(3);
        gapped = 1'b0;
        startTransfer();
        applyStimulus(10, -1);
        waitEnd();
        checkWrites(1);
        checkOutput("to_err_cnt", err_cnt, 1);
        checkOutput("to_done_cnt", done_cnt, 0);
        checkOutput("to_err_cycle", err_cyc, acc_q[acc_q.size() - 1] + TIMEOUT);
        checkOutput("to_hold_fall", hold_fall_cyc, err_cyc + 1);
        checkOutput("to_rx_ready", rx_ready, 0);

        // dl_start in the middle of the data phase must be ignored
        randomWords(3);
        buildFrame(3);
        gapped = 1'b1;
        startTransfer();
        applyStimulus(tx_q.size(), 9);
        waitEnd();
        checkSuccess();

        // Reset in the middle of the data phase, then a clean restart
        randomWords(4);
        buildFrame(4);
        gapped = 1'b0;
        startTransfer();
        applyStimulus(14, -1);
        #1 rst_n = 1'b0;
        #1 checkIdleOutputs("midrst");
        @(posedge clk); #1 rst_n = 1'b1;

        randomWords(2);
        buildFrame(2);
        startTransfer();
        applyStimulus(tx_q.size(), -1);
        waitEnd();
        checkSuccess();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
